// File: rtl/fft_frame_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_driver_if
// Purpose  : Bundles the three streams that fft_frame_driver sits between:
//            the host sample stream, the FFT core strobe/data pair and the
//            host result stream. The driver uses the slave view and its
//            environment uses the master view.
// Signals  : in_valid/in_data/in_ready        host sample stream
//            readyin/core_din/core_dout       FFT core strobe and data
//            res_valid/res_data/res_last/res_ready  host result stream
//            busy                             driver is not accepting input
// Revision : 1.0  initial release
// ============================================================================
interface fft_frame_driver_if #(
  parameter int DATA_W = 16
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              readyin;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              res_ready;
  logic              busy;

  // Driver side
  modport slave (
    input  in_valid, in_data, core_dout, res_ready,
    output in_ready, readyin, core_din, res_valid, res_data, res_last, busy
  );

  // Host and core side
  modport master (
    output in_valid, in_data, core_dout, res_ready,
    input  in_ready, readyin, core_din, res_valid, res_data, res_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/fft_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_driver
// Purpose  : Host-side driver for an FFT core with a single-strobe readyin
//            handshake. Collects one frame of N_IN samples, strobes each into
//            the core, waits out the core compute window, strobes N_OUT+1
//            readout pulses while capturing N_OUT result words, then returns
//            the results on a valid/ready stream.
// Ports    : clock      rising-edge clock
//            n_rst      synchronous active-low reset (shared with the core)
//            bus        fft_frame_driver_if.slave:
//                         in_valid/in_data/in_ready      sample input
//                         readyin/core_din/core_dout     core strobe and data
//                         res_valid/res_data/res_last/res_ready  results
//                         busy                           high outside COLLECT
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_driver #(
  parameter int DATA_W         = 16,
  parameter int N_IN           = 4,
  parameter int N_OUT          = 4,
  parameter int PULSE_HIGH     = 2,
  parameter int PULSE_LOW      = 2,
  parameter int COMPUTE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              n_rst,
  fft_frame_driver_if.slave bus
);

  // --------------------------------------------------------------------------
  // Counter sizing
  // --------------------------------------------------------------------------
  localparam int c_tmax_a = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int c_tmax   = (c_tmax_a > COMPUTE_CYCLES) ? c_tmax_a : COMPUTE_CYCLES;
  // Pulse counter must reach N_OUT (index of the extra idle-return pulse)
  localparam int c_pmax   = (N_IN > N_OUT + 1) ? N_IN : N_OUT + 1;

  localparam int c_tc_w = $clog2(c_tmax + 1);
  localparam int c_pc_w = $clog2(c_pmax + 1);
  localparam int c_wc_w = $clog2(N_IN + 1);
  localparam int c_rc_w = $clog2(N_OUT + 1);

  localparam logic [c_tc_w-1:0] c_ph_last   = c_tc_w'(PULSE_HIGH - 1);
  localparam logic [c_tc_w-1:0] c_pl_last   = c_tc_w'(PULSE_LOW - 1);
  localparam logic [c_tc_w-1:0] c_cc_last   = c_tc_w'(COMPUTE_CYCLES - 1);
  localparam logic [c_wc_w-1:0] c_wc_last   = c_wc_w'(N_IN - 1);
  localparam logic [c_wc_w-1:0] c_wc_full   = c_wc_w'(N_IN);
  localparam logic [c_pc_w-1:0] c_pc_in_end = c_pc_w'(N_IN - 1);
  localparam logic [c_pc_w-1:0] c_pc_rd_end = c_pc_w'(N_OUT);
  localparam logic [c_pc_w-1:0] c_pc_n_out  = c_pc_w'(N_OUT);
  localparam logic [c_rc_w-1:0] c_rc_last   = c_rc_w'(N_OUT - 1);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_WAIT    = 3'd3,
    S_READ_HI = 3'd4,
    S_READ_LO = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_wc_w-1:0] r_wc, w_wc_nxt;   // input word count
  logic [c_pc_w-1:0] r_pc, w_pc_nxt;   // pulse count within a phase
  logic [c_tc_w-1:0] r_tc, w_tc_nxt;   // cycle timer within a pulse / wait
  logic [c_rc_w-1:0] r_rc, w_rc_nxt;   // result read index

  logic              r_readyin;
  logic [DATA_W-1:0] r_core_din;
  logic [DATA_W-1:0] w_din_nxt;

  logic [DATA_W-1:0] r_ibuf [N_IN];
  logic [DATA_W-1:0] r_obuf [N_OUT];

  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_res_xfer;
  logic              w_cap;
  logic [c_pc_w-1:0] w_pc_inc;
  logic [DATA_W-1:0] w_res_data;

  // in_ready is a function of state and count only, never of in_valid
  assign w_in_ready = (r_state == S_COLLECT) && (r_wc != c_wc_full);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_res_xfer = (r_state == S_DRAIN) && bus.res_ready;
  assign w_pc_inc   = r_pc + 1'b1;

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wc_nxt    = r_wc;
    w_pc_nxt    = r_pc;
    w_tc_nxt    = r_tc;
    w_rc_nxt    = r_rc;
    w_din_nxt   = r_core_din;
    w_cap       = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (w_in_xfer) begin
          if (r_wc == c_wc_last) begin
            w_state_nxt = S_LOAD_HI;
            w_wc_nxt    = '0;
            w_pc_nxt    = '0;
            w_tc_nxt    = '0;
            // Word 0 goes to the core on the first pulse. With a one-word
            // frame it is still in flight on in_data this cycle.
            w_din_nxt   = (N_IN == 1) ? bus.in_data : r_ibuf[0];
          end else begin
            w_wc_nxt = r_wc + 1'b1;
          end
        end
      end

      S_LOAD_HI: begin
        if (r_tc == c_ph_last) begin
          w_state_nxt = S_LOAD_LO;
          w_tc_nxt    = '0;
        end else begin
          w_tc_nxt = r_tc + 1'b1;
        end
      end

      S_LOAD_LO: begin
        if (r_tc == c_pl_last) begin
          w_tc_nxt = '0;
          if (r_pc == c_pc_in_end) begin
            w_state_nxt = S_WAIT;
            w_pc_nxt    = '0;
          end else begin
            w_state_nxt = S_LOAD_HI;
            w_pc_nxt    = w_pc_inc;
            // Next word is registered on entry to LOAD_HI so core_din only
            // changes on the first high cycle of each pulse.
            for (int i = 0; i < N_IN; i++) begin
              if (w_pc_inc == c_pc_w'(i)) begin
                w_din_nxt = r_ibuf[i];
              end
            end
          end
        end else begin
          w_tc_nxt = r_tc + 1'b1;
        end
      end

      S_WAIT: begin
        if (r_tc == c_cc_last) begin
          w_state_nxt = S_READ_HI;
          w_tc_nxt    = '0;
        end else begin
          w_tc_nxt = r_tc + 1'b1;
        end
      end

      S_READ_HI: begin
        if (r_tc == c_ph_last) begin
          w_state_nxt = S_READ_LO;
          w_tc_nxt    = '0;
        end else begin
          w_tc_nxt = r_tc + 1'b1;
        end
      end

      S_READ_LO: begin
        if (r_tc == c_pl_last) begin
          w_tc_nxt = '0;
          // The core presents result r_pc after readout pulse r_pc+1; the
          // final pulse only returns the core sequencer to idle.
          w_cap    = (r_pc < c_pc_n_out);
          if (r_pc == c_pc_rd_end) begin
            w_state_nxt = S_DRAIN;
            w_pc_nxt    = '0;
            w_rc_nxt    = '0;
          end else begin
            w_state_nxt = S_READ_HI;
            w_pc_nxt    = w_pc_inc;
          end
        end else begin
          w_tc_nxt = r_tc + 1'b1;
        end
      end

      S_DRAIN: begin
        if (w_res_xfer) begin
          if (r_rc == c_rc_last) begin
            w_state_nxt = S_COLLECT;
            w_rc_nxt    = '0;
          end else begin
            w_rc_nxt = r_rc + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_COLLECT;
        w_wc_nxt    = '0;
        w_pc_nxt    = '0;
        w_tc_nxt    = '0;
        w_rc_nxt    = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, strobe and buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_wc       <= '0;
      r_pc       <= '0;
      r_tc       <= '0;
      r_rc       <= '0;
      r_readyin  <= 1'b0;
      r_core_din <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_ibuf[i] <= '0;
      end
      for (int i = 0; i < N_OUT; i++) begin
        r_obuf[i] <= '0;
      end
    end else begin
      r_wc       <= w_wc_nxt;
      r_pc       <= w_pc_nxt;
      r_tc       <= w_tc_nxt;
      r_rc       <= w_rc_nxt;
      // Registered from the next state so the core sees a glitch-free strobe
      r_readyin  <= (w_state_nxt == S_LOAD_HI) || (w_state_nxt == S_READ_HI);
      r_core_din <= w_din_nxt;
      for (int i = 0; i < N_IN; i++) begin
        if (w_in_xfer && (r_wc == c_wc_w'(i))) begin
          r_ibuf[i] <= bus.in_data;
        end
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (w_cap && (r_pc == c_pc_w'(i))) begin
          r_obuf[i] <= bus.core_dout;
        end
      end
    end
  end

  // Result word select; r_rc only moves on a transfer so data holds under
  // backpressure.
  always_comb begin
    w_res_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (r_rc == c_rc_w'(i)) begin
        w_res_data = r_obuf[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.readyin   = r_readyin;
  assign bus.core_din  = r_core_din;
  assign bus.res_valid = (r_state == S_DRAIN);
  assign bus.res_data  = w_res_data;
  assign bus.res_last  = (r_state == S_DRAIN) && (r_rc == c_rc_last);
  assign bus.busy      = (r_state != S_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_driver
// Purpose  : Self-checking bench for fft_frame_driver. A behavioural FFT core
//            latches loaded words and answers readout pulses with word+0x9F;
//            a monitor timestamps every readyin rise. Each frame is checked
//            for pulse counts, spacing, latency, core_din alignment, result
//            order/values, res_last placement and backpressure hold.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_driver;

  localparam int DATA_W = 16;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int PH     = 2;
  localparam int PL     = 2;
  localparam int CC     = 16;
  localparam int N_RISE = N_IN + N_OUT + 1;

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  fft_frame_driver_if #(.DATA_W(DATA_W)) bus ();

  fft_frame_driver #(
    .DATA_W        (DATA_W),
    .N_IN          (N_IN),
    .N_OUT         (N_OUT),
    .PULSE_HIGH    (PH),
    .PULSE_LOW     (PL),
    .COMPUTE_CYCLES(CC)
  ) u_dut (
    .clock(clock),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Behavioural FFT core: counts readyin rises; first N_IN latch core_din,
  // next N_OUT present latched word + 0x9F, last one returns to idle.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] core_lat [N_IN];
  int                core_cnt  = 0;
  logic              core_prev = 1'b0;

  initial begin
    bus.core_dout = '0;
    forever begin
      @(negedge clock);
      if (!n_rst) begin
        core_cnt      = 0;
        core_prev     = 1'b0;
        bus.core_dout = '0;
      end else begin
        if (bus.readyin && !core_prev) begin
          if (core_cnt < N_IN) begin
            core_lat[core_cnt] = bus.core_din;
            bus.core_dout      = 16'hBEEF;
          end else if (core_cnt < N_IN + N_OUT) begin
            bus.core_dout = core_lat[core_cnt - N_IN] + 16'h009F;
          end else begin
            bus.core_dout = 16'hDEAD;
          end
          core_cnt = (core_cnt + 1) % N_RISE;
        end
        core_prev = bus.readyin;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  int                rise_cyc [$];
  logic [DATA_W-1:0] rise_din [$];
  int                hi_cnt          = 0;
  int                xfer_cnt        = 0;
  int                first_xfer_cyc  = -1;
  int                last_xfer_cyc   = -1;
  int                first_valid_cyc = -1;
  int                valid_cycles    = 0;
  logic              mon_prev        = 1'b0;
  bit                mon_en          = 1'b0;

  initial forever begin
    @(negedge clock);
    if (!n_rst) begin
      mon_prev = 1'b0;
    end else begin
      if (bus.readyin && !mon_prev) begin
        rise_cyc.push_back(cyc);
        rise_din.push_back(bus.core_din);
      end
      if (bus.readyin) hi_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (bus.res_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        valid_cycles++;
      end
      if (mon_en) chk_eq("in_ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
      mon_prev = bus.readyin;
    end
  end

  task automatic clear_monitor();
    rise_cyc.delete();
    rise_din.delete();
    hi_cnt          = 0;
    xfer_cnt        = 0;
    first_xfer_cyc  = -1;
    last_xfer_cyc   = -1;
    first_valid_cyc = -1;
    valid_cycles    = 0;
  endtask

  // --------------------------------------------------------------------------
  // One frame. Called and returns at posedge+1.
  //   fixed: 1 -> words 1..N_IN, else random
  //   gap  : idle cycles after each accepted word
  //   stall: 0 res_ready=1, 1 pattern 1-0-0-1, 2 random
  //   junk : hold in_valid high with junk once the frame is sent
  // --------------------------------------------------------------------------
  task automatic run_frame(input bit fixed, input int gap, input int stall, input bit junk,
                           input int prev_last, output int last_res);
    logic [DATA_W-1:0] words   [N_IN];
    logic [DATA_W-1:0] exp_res [N_OUT];
    int                wi, ri, gap_cnt, t;
    bit                hold_v;
    logic [DATA_W-1:0] hold_d;
    logic              hold_l;

    for (int i = 0; i < N_IN; i++) words[i] = fixed ? DATA_W'(i + 1) : DATA_W'($urandom);
    for (int k = 0; k < N_OUT; k++) exp_res[k] = words[k] + 16'h009F;
    clear_monitor();
    wi = 0; ri = 0; gap_cnt = 0; t = 0; hold_v = 1'b0; hold_d = '0; hold_l = 1'b0;
    last_res = -1;

    while (ri < N_OUT && t < 600) begin
      if (wi < N_IN && gap_cnt == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = words[wi];
      end else if (wi < N_IN) begin
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
      end else begin
        bus.in_valid = junk;
        bus.in_data  = DATA_W'($urandom);
      end
      case (stall)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase

      @(negedge clock);
      if (wi < N_IN && bus.in_valid && bus.in_ready) begin
        wi++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end

      if (hold_v) begin
        chk_eq("hold_valid", 32'(bus.res_valid), 32'd1);
        chk_eq("hold_data", 32'(bus.res_data), 32'(hold_d));
        chk_eq("hold_last", 32'(bus.res_last), 32'(hold_l));
      end
      hold_v = 1'b0;
      if (bus.res_valid) begin
        if (bus.res_ready) begin
          chk_eq("res_data", 32'(bus.res_data), 32'(exp_res[ri]));
          chk_eq("res_last", 32'(bus.res_last), 32'(ri == N_OUT - 1));
          last_res = cyc;
          ri++;
        end else begin
          hold_v = 1'b1;
          hold_d = bus.res_data;
          hold_l = bus.res_last;
        end
      end
      @(posedge clock);
      #1;
      t++;
    end

    chk_eq("frame_results", 32'(ri), 32'(N_OUT));
    chk_eq("in_xfers", 32'(xfer_cnt), 32'(N_IN));
    if (prev_last >= 0) chk_eq("b2b_accept", 32'(first_xfer_cyc), 32'(prev_last + 1));
    chk_eq("rise_count", 32'(rise_cyc.size()), 32'(N_RISE));
    chk_eq("hi_cycles", 32'(hi_cnt), 32'(N_RISE * PH));
    if (stall == 0) chk_eq("drain_len", 32'(valid_cycles), 32'(N_OUT));
    if (rise_cyc.size() == N_RISE) begin
      chk_eq("load_latency", 32'(rise_cyc[0]), 32'(last_xfer_cyc + 1));
      for (int i = 0; i < N_IN; i++) begin
        chk_eq("core_din", 32'(rise_din[i]), 32'(words[i]));
        if (i > 0) chk_eq("load_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'(PH + PL));
      end
      chk_eq("compute_gap", 32'(rise_cyc[N_IN] - rise_cyc[N_IN-1]), 32'(PH + PL + CC));
      for (int i = N_IN + 1; i < N_RISE; i++) begin
        chk_eq("read_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'(PH + PL));
      end
      chk_eq("valid_latency", 32'(first_valid_cyc), 32'(rise_cyc[N_RISE-1] + PH + PL));
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  int last_res;
  int t0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    n_rst         = 1'b0;
    repeat (3) @(posedge clock);
    #1 n_rst = 1'b1;
    @(negedge clock);
    chk_eq("rst_readyin", 32'(bus.readyin), 32'd0);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk_eq("rst_res_last", 32'(bus.res_last), 32'd0);
    chk_eq("rst_core_din", 32'(bus.core_din), 32'd0);
    chk_eq("rst_res_data", 32'(bus.res_data), 32'd0);
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    // Abort a frame with reset while the first readout pulse is high
    clear_monitor();
    for (int i = 0; i < N_IN; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'($urandom);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    t0 = 0;
    while (rise_cyc.size() < N_IN + 1 && t0 < 200) begin
      @(posedge clock);
      #1;
      t0++;
    end
    chk_eq("abort_reached_read", 32'(rise_cyc.size()), 32'(N_IN + 1));
    chk_eq("abort_in_read_hi", 32'(bus.readyin), 32'd1);
    n_rst = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_eq("abort_readyin_next", 32'(bus.readyin), 32'd0);
    repeat (2) @(posedge clock);
    #1 n_rst = 1'b1;
    @(negedge clock);
    chk_eq("abort_readyin", 32'(bus.readyin), 32'd0);
    chk_eq("abort_busy", 32'(bus.busy), 32'd0);
    chk_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk_eq("abort_res_valid", 32'(bus.res_valid), 32'd0);
    chk_eq("abort_core_idle", 32'(core_cnt), 32'd0);
    @(posedge clock);
    #1;

    // Fixed 1..4 frame, no backpressure
    run_frame(1'b1, 0, 0, 1'b0, -1, last_res);
    // Random words, res_ready 1-0-0-1, junk valid while busy
    run_frame(1'b0, 0, 1, 1'b1, last_res, last_res);
    // One valid every 3 cycles, random backpressure
    run_frame(1'b0, 2, 2, 1'b1, last_res, last_res);
    // Back-to-back frames with host pushing during drain
    run_frame(1'b0, 0, 2, 1'b1, last_res, last_res);
    run_frame(1'b0, 1, 0, 1'b1, last_res, last_res);

    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    @(negedge clock);
    chk_eq("end_res_valid", 32'(bus.res_valid), 32'd0);
    chk_eq("end_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
